// File: rtl/debounce_pkg.sv
// Shared types and constants for the bounce_gen switch-contact emulator.
//   bounce_state_e : FSM state encoding (IDLE, BOUNCE, SETTLE)
//   LfsrTaps       : Galois taps for x^16+x^14+x^13+x^11+1 (right-shifting form)
//   DefaultSeed    : LFSR reset value
//   lfsr_next()    : one Galois LFSR step
package debounce_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BOUNCE = 2'd1,
    SETTLE = 2'd2
  } bounce_state_e;

  localparam logic [15:0] LfsrTaps    = 16'hB400;
  localparam logic [15:0] DefaultSeed = 16'hACE1;

  // Right-shifting Galois step: the bit shifted out feeds back through the taps.
  function automatic logic [15:0] lfsr_next(logic [15:0] cur);
    logic [15:0] nxt;
    nxt = cur >> 1;
    if (cur[0]) begin
      nxt = nxt ^ LfsrTaps;
    end
    return nxt;
  endfunction

endpackage

// File: rtl/bounce_gen_if.sv
// Signal bundle between a clean-level source and the bounce_gen emulator.
//   level_i     : clean target level (driven by master)
//   sw_o        : emulated bouncing contact (driven by slave)
//   busy_o      : slave is mid-sequence
//   done_tick_o : one-cycle completion pulse
// Modports: master = level source / observer, slave = bounce_gen.
interface bounce_gen_if;

  logic level_i;
  logic sw_o;
  logic busy_o;
  logic done_tick_o;

  modport master (
    output level_i,
    input  sw_o,
    input  busy_o,
    input  done_tick_o
  );

  modport slave (
    input  level_i,
    output sw_o,
    output busy_o,
    output done_tick_o
  );

endinterface

// File: rtl/lfsr16.sv
// Free-running 16-bit Galois LFSR, advanced on every clock.
//   clk_i  : clock (rising edge)
//   rst_i  : asynchronous active-high reset, loads seed_i
//   seed_i : reset value (must be nonzero)
//   q_o    : current LFSR state
module lfsr16
  import debounce_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] seed_i,
  output logic [15:0] q_o
);

  logic [15:0] lfsr_q, lfsr_d;

  always_comb begin
    lfsr_d = lfsr_next(lfsr_q);
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      lfsr_q <= seed_i;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign q_o = lfsr_q;

endmodule

// File: rtl/bounce_gen.sv
// Emulates a mechanical switch: each change of the clean level is reproduced on
// sw_o as NumBounces extra toggles of length len, followed by a stable hold of
// SettleCycles, then a one-cycle done tick. A level change mid-sequence restarts it.
//   clk_i  : clock (rising edge)
//   rst_i  : asynchronous active-high reset
//   bus    : bounce_gen_if.slave (level_i in; sw_o, busy_o, done_tick_o out, all registered)
// Build option: define BOUNCE_GEN_RANDOM_EN to randomise segment lengths as
// MinPulse + lfsr[$clog2(PulseSpan)-1:0]; otherwise every segment is MinPulse
// cycles and no LFSR is built.
module bounce_gen
  import debounce_pkg::*;
#(
  parameter int unsigned MinPulse     = 4,
  parameter int unsigned PulseSpan    = 16,
  parameter int unsigned NumBounces   = 4,
  parameter int unsigned SettleCycles = 20,
  parameter logic [15:0] Seed         = DefaultSeed
) (
  input logic         clk_i,
  input logic         rst_i,
  bounce_gen_if.slave bus
);

`ifdef BOUNCE_GEN_RANDOM_EN
  localparam int unsigned LenMax = MinPulse + PulseSpan - 1;
`else
  localparam int unsigned LenMax = MinPulse;
`endif
  // seg_cnt holds either len-1 or SettleCycles-1; size it for the larger.
  localparam int unsigned SegMax = (LenMax > SettleCycles) ? LenMax - 1 : SettleCycles - 1;
  localparam int unsigned SegW   = (SegMax > 0) ? $clog2(SegMax + 1) : 1;
  localparam int unsigned BncW   = (NumBounces > 0) ? $clog2(NumBounces + 1) : 1;

  if (MinPulse < 1 || SettleCycles < 1 || Seed == 16'h0000 || PulseSpan == 0 ||
      (PulseSpan & (PulseSpan - 1)) != 0 || (NumBounces % 2) != 0) begin : g_param_err
    $error("bounce_gen: illegal parameter set");
  end

  bounce_state_e   state_q, state_d;
  logic            target_q, target_d;
  logic            sw_q, sw_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [SegW-1:0] seg_q, seg_d;
  logic [BncW-1:0] bnc_q, bnc_d;
  logic [SegW-1:0] len_m1;

`ifdef BOUNCE_GEN_RANDOM_EN
  logic [15:0] lfsr_q;
  logic [15:0] rnd;

  lfsr16 u_lfsr (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .seed_i (Seed),
    .q_o    (lfsr_q)
  );

  // PulseSpan is a power of two, so the mask keeps the low $clog2(PulseSpan) bits.
  assign rnd    = lfsr_q & 16'(PulseSpan - 1);
  assign len_m1 = SegW'(MinPulse - 1) + SegW'(rnd);
`else
  assign len_m1 = SegW'(MinPulse - 1);
`endif

  always_comb begin
    state_d  = state_q;
    target_d = target_q;
    sw_d     = sw_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    seg_d    = seg_q;
    bnc_d    = bnc_q;

    // A level change restarts from any state and outranks segment expiry.
    if (bus.level_i != target_q) begin
      state_d  = BOUNCE;
      target_d = bus.level_i;
      sw_d     = bus.level_i;
      busy_d   = 1'b1;
      seg_d    = len_m1;
      bnc_d    = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
        end
        BOUNCE: begin
          if (seg_q != '0) begin
            seg_d = seg_q - SegW'(1);
          end else if (bnc_q == BncW'(NumBounces)) begin
            state_d = SETTLE;
            sw_d    = target_q;
            seg_d   = SegW'(SettleCycles - 1);
          end else begin
            sw_d  = ~sw_q;
            bnc_d = bnc_q + BncW'(1);
            seg_d = len_m1;
          end
        end
        SETTLE: begin
          if (seg_q != '0) begin
            seg_d = seg_q - SegW'(1);
          end else begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
        default: begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      target_q <= 1'b0;
      sw_q     <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      seg_q    <= '0;
      bnc_q    <= '0;
    end else begin
      state_q  <= state_d;
      target_q <= target_d;
      sw_q     <= sw_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      seg_q    <= seg_d;
      bnc_q    <= bnc_d;
    end
  end

  assign bus.sw_o        = sw_q;
  assign bus.busy_o      = busy_q;
  assign bus.done_tick_o = done_q;

endmodule

// File: tb/tb_bounce_gen.sv
// Bench for bounce_gen. A queue-based model expands each level change into the
// full per-cycle output schedule (segments, settle, done) and is compared with
// the DUT every cycle; directed literal checks pin the model's timing.
module tb_bounce_gen;
  import debounce_pkg::*;

  localparam int unsigned MinPulse     = 4;
  localparam int unsigned PulseSpan    = 16;
  localparam int unsigned NumBounces   = 4;
  localparam int unsigned SettleCycles = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bounce_gen_if bif ();

  bounce_gen #(
    .MinPulse     (MinPulse),
    .PulseSpan    (PulseSpan),
    .NumBounces   (NumBounces),
    .SettleCycles (SettleCycles),
    .Seed         (16'hACE1)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bif.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  typedef struct packed {
    logic sw;
    logic busy;
    logic done;
  } exp_t;

  exp_t        sched[$];
  exp_t        m_exp;
  logic        m_target;
  logic [15:0] m_lfsr;

  function automatic logic [15:0] step(logic [15:0] x);
    return x[0] ? ((x >> 1) ^ 16'hB400) : (x >> 1);
  endfunction

  function automatic int seg_len(logic [15:0] l);
`ifdef BOUNCE_GEN_RANDOM_EN
    return int'(MinPulse) + int'(l % 16'(PulseSpan));
`else
    return int'(MinPulse);
`endif
  endfunction

  // Expand a transition to level lvl, seen at an edge whose pre-edge LFSR is l0.
  task automatic build(input logic lvl, input logic [15:0] l0);
    logic [15:0] l;
    int          len;
    sched.delete();
    l = l0;
    for (int i = 0; i <= int'(NumBounces); i++) begin
      len = seg_len(l);
      for (int j = 0; j < len; j++) sched.push_back('{lvl ^ 1'(i % 2), 1'b1, 1'b0});
      for (int j = 0; j < len; j++) l = step(l);
    end
    for (int j = 0; j < int'(SettleCycles); j++) sched.push_back('{lvl, 1'b1, 1'b0});
    sched.push_back('{lvl, 1'b0, 1'b1});
  endtask

  initial begin : model
    logic [15:0] pre;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        sched.delete();
        m_target = 1'b0;
        m_lfsr   = 16'hACE1;
        m_exp    = '0;
      end else begin
        pre    = m_lfsr;
        m_lfsr = step(m_lfsr);
        if (bif.level_i !== m_target) begin
          m_target = bif.level_i;
          build(bif.level_i, pre);
        end
        if (sched.size() > 0) m_exp = sched.pop_front();
        else m_exp = '{m_target, 1'b0, 1'b0};
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  initial begin : compare
    forever begin
      @(posedge clk);
      #3;
      if (rst) begin
        check("rst_sw", {31'b0, bif.sw_o}, 32'd0);
        check("rst_busy", {31'b0, bif.busy_o}, 32'd0);
        check("rst_done", {31'b0, bif.done_tick_o}, 32'd0);
`ifdef BOUNCE_GEN_RANDOM_EN
        check("rst_lfsr", {16'b0, dut.u_lfsr.q_o}, 32'hACE1);
`endif
      end else begin
        check("sw", {31'b0, bif.sw_o}, {31'b0, m_exp.sw});
        check("busy", {31'b0, bif.busy_o}, {31'b0, m_exp.busy});
        check("done", {31'b0, bif.done_tick_o}, {31'b0, m_exp.done});
`ifdef BOUNCE_GEN_RANDOM_EN
        check("lfsr_nonzero", {31'b0, dut.u_lfsr.q_o != 16'h0}, 32'd1);
`endif
      end
    end
  end

`ifndef BOUNCE_GEN_RANDOM_EN
  // Fixed timing: sw reads lvl,~lvl,lvl,~lvl,lvl in 4-cycle segments, then holds
  // lvl; busy for exactly 40 cycles, done after edge k+40.
  task automatic literal_seq(input logic lvl);
    logic [19:0] pat;
    int          busy_n;
    int          done_at;
    pat     = 20'b1111_0000_1111_0000_1111;
    busy_n  = 0;
    done_at = -1;
    bif.level_i = lvl;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (c < 20) check("lit_seg_sw", {31'b0, bif.sw_o}, {31'b0, lvl ? pat[c] : ~pat[c]});
      else if (c < 40) check("lit_settle_sw", {31'b0, bif.sw_o}, {31'b0, lvl});
      if (bif.busy_o) busy_n++;
      if (bif.done_tick_o && done_at < 0) done_at = c;
    end
    check("lit_busy_cycles", busy_n, 40);
    check("lit_done_edge", done_at, 40);
    check("lit_final_sw", {31'b0, bif.sw_o}, {31'b0, lvl});
  endtask
`endif

  // ---------------- stimulus ----------------
  initial begin : stim
    int done_n;
    int done_at;
    bif.level_i = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // No-op: level equals target.
    repeat (20) @(negedge clk);
    check("noop_busy", {31'b0, bif.busy_o}, 32'd0);
    check("noop_sw", {31'b0, bif.sw_o}, 32'd0);

`ifndef BOUNCE_GEN_RANDOM_EN
    literal_seq(1'b1);
    literal_seq(1'b0);
`else
    bif.level_i = 1'b1;
    repeat (130) @(negedge clk);
    bif.level_i = 1'b0;
    repeat (130) @(negedge clk);
`endif

    // Restart during the third segment.
    bif.level_i = 1'b1;
    repeat (9) @(negedge clk);
`ifndef BOUNCE_GEN_RANDOM_EN
    check("restart_pre_sw", {31'b0, bif.sw_o}, 32'd1);
`endif
    bif.level_i = 1'b0;
    @(negedge clk);
    check("restart_sw", {31'b0, bif.sw_o}, 32'd0);
    check("restart_busy", {31'b0, bif.busy_o}, 32'd1);
    done_n  = 0;
    done_at = -1;
    for (int c = 1; c <= 130; c++) begin
      @(negedge clk);
      if (bif.done_tick_o) begin
        done_n++;
        if (done_at < 0) done_at = c;
      end
    end
    check("restart_done_count", done_n, 1);
`ifndef BOUNCE_GEN_RANDOM_EN
    check("restart_done_edge", done_at, 40);
`endif

    // Reset mid-sequence.
    bif.level_i = 1'b1;
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    check("midrst_sw", {31'b0, bif.sw_o}, 32'd0);
    check("midrst_busy", {31'b0, bif.busy_o}, 32'd0);
    check("midrst_done", {31'b0, bif.done_tick_o}, 32'd0);
`ifdef BOUNCE_GEN_RANDOM_EN
    check("midrst_lfsr", {16'b0, dut.u_lfsr.q_o}, 32'hACE1);
`endif
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (130) @(negedge clk);
    check("post_rst_sw", {31'b0, bif.sw_o}, 32'd1);
    check("post_rst_busy", {31'b0, bif.busy_o}, 32'd0);

    // Level toggles at varied spacings, many landing mid-sequence.
    repeat (40) begin
      bif.level_i = ~bif.level_i;
      repeat ($urandom_range(1, 150)) @(negedge clk);
    end
    repeat (130) @(negedge clk);
    check("final_sw", {31'b0, bif.sw_o}, {31'b0, bif.level_i});
    check("final_busy", {31'b0, bif.busy_o}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/bounce_gen.md
BOUNCE_GEN -- requirements
Module: bounce_gen

Interface
REQ-001 The block SHALL have parameter MinPulse, default 4, giving the minimum bounce segment length in clk_i cycles (>=1).
REQ-002 The block SHALL have parameter PulseSpan, default 16, a power of two giving the random extra segment length range 0..PulseSpan-1.
REQ-003 The block SHALL have parameter NumBounces, default 4, giving the number of extra toggles per transition (even, >=0).
REQ-004 The block SHALL have parameter SettleCycles, default 20, giving the stable hold time before completion (>=1).
REQ-005 The block SHALL have parameter Seed, default 16'hACE1, giving the LFSR reset value (nonzero).
REQ-006 The block SHALL have port clk_i, input, 1 bit: the single clock; all logic SHALL be on its rising edge.
REQ-007 The block SHALL have port rst_i, input, 1 bit: an asynchronous, active-high reset.
REQ-008 The block SHALL have port level_i, input, 1 bit: the clean target level, synchronous to clk_i.
REQ-009 The block SHALL have port sw_o, output, 1 bit: the emulated bouncing switch contact.
REQ-010 The block SHALL have port busy_o, output, 1 bit: high while not in IDLE.
REQ-011 The block SHALL have port done_tick_o, output, 1 bit: a one-cycle pulse at completion.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, BOUNCE and SETTLE.
REQ-013 On any edge in IDLE with level_i != target, the FSM SHALL set target<=level_i, sw_o<=level_i, bounce_cnt<=0 and seg_cnt<=len-1, and go to BOUNCE.
REQ-014 len SHALL equal MinPulse + lfsr[$clog2(PulseSpan)-1:0].
REQ-015 In BOUNCE, seg_cnt SHALL decrement each cycle, so that each segment lasts exactly len cycles.
REQ-016 In BOUNCE, when seg_cnt==0 and bounce_cnt<NumBounces, the block SHALL toggle sw_o, increment bounce_cnt and reload seg_cnt with a fresh len-1.
REQ-017 In BOUNCE, when seg_cnt==0 and bounce_cnt==NumBounces, the block SHALL set sw_o<=target, load seg_cnt<=SettleCycles-1 and go to SETTLE.
REQ-018 In BOUNCE or SETTLE, on any edge with level_i != target, the block SHALL restart the sequence exactly as in REQ-013; the restart SHALL take priority over segment expiry on the same edge.
REQ-019 In SETTLE, sw_o SHALL hold target, and at seg_cnt==0 the block SHALL assert done_tick_o for one cycle and return to IDLE.
REQ-020 busy_o SHALL be registered, rising on the edge that enters BOUNCE and falling on the edge that returns to IDLE.
REQ-021 sw_o, busy_o and done_tick_o SHALL all be registered, with no combinational path from level_i.
REQ-022 The LFSR SHALL be a 16-bit Galois LFSR with polynomial x^16+x^14+x^13+x^11+1, advanced every cycle regardless of state.
REQ-023 Counter widths SHALL be derived with $clog2 of the maximum count, and counters SHALL never wrap.

Reset
REQ-024 While rst_i is high, the block SHALL hold state=IDLE, target=0, sw_o=0, busy_o=0, done_tick_o=0, all counters=0 and lfsr=Seed.
REQ-025 A reset asserted mid-sequence SHALL abort the sequence immediately, with no done_tick_o.

Configuration
REQ-026 With BOUNCE_GEN_RANDOM_EN defined, len SHALL follow REQ-014.
REQ-027 With BOUNCE_GEN_RANDOM_EN undefined, len SHALL equal MinPulse, and the LFSR and its sub-module SHALL not be instantiated.

Structure
REQ-028 Package debounce_pkg SHALL hold the bounce_state_e enum (IDLE, BOUNCE, SETTLE), LfsrTaps=16'hB400 and DefaultSeed=16'hACE1.
REQ-029 The LFSR SHALL be the sub-module lfsr16 (ports clk_i, rst_i, seed_i, q_o).

Verification
REQ-030 Fixed timing (macro undefined, defaults): with level_i going 0->1 before edge k, sw_o SHALL read 1,0,1,0,1 in 4-cycle segments from edge k, then stay 1 for 20 cycles; done_tick_o SHALL pulse at edge k+40 and busy_o SHALL be high for exactly 40 cycles.
REQ-031 Falling transition: level_i going 1->0 SHALL produce the mirror pattern 0,1,0,1,0 and settle at 0.
REQ-032 Restart: level_i returning to 0 during the third segment SHALL make sw_o drive 0 on the next edge, restart bounce_cnt and produce a single done_tick_o only after the full new sequence.
REQ-033 Reset: rst_i asserted at cycle k+10 SHALL force sw_o=0 and busy_o=0 immediately with no done_tick_o, and lfsr SHALL read 16'hACE1.
REQ-034 Random timing (macro defined): over 1000 transitions, every segment length SHALL lie in 4..19, sw_o SHALL always end equal to level_i, and the LFSR SHALL never reach 0.
REQ-035 No-op: level_i held equal to target SHALL keep busy_o=0 and done_tick_o=0 indefinitely.
